// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//
// Two-master arbiter in front of a single data memory port. Each access runs
// IDLE -> ACCESS -> RESP -> IDLE. In IDLE one requester is chosen and its
// command is latched. In ACCESS the memory is driven and the requester receives
// a grant pulse. In RESP the requester receives a done pulse, plus err if the
// access was misaligned.
//
// Build option:
//   DM_ARB_RR_EN  defined   -> round-robin arbitration (last winner yields)
//                 undefined -> m0 fixed priority; m1 wins after MAX_BURST
//                              consecutive m0 grants while it is waiting
//
// Ports:
//   clk, reset                  clock (rising edge), async active-high reset
//   mN_req/we/ls_op/addr/wdata  request and command from master N (N=0,1)
//   mN_gnt, mN_done, mN_err     grant, completion and misalignment pulses
//   m_rdata                     load data, held until the next capture
//   dm_we/ls_op/addr/wdata      memory drive, zero outside ACCESS
//   dm_rdata                    combinational memory read data
//   busy                        high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module dm_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_ls_op,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_ls_op,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic        m0_err,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic        m1_err,
    output logic [31:0] m_rdata,
    output logic        dm_we,
    output logic [1:0]  dm_ls_op,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_win;      // 0 = m0, 1 = m1
    logic        r_we;
    logic [1:0]  r_ls_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        w_win;
    logic        w_any;
    logic        w_start;
    logic        w_access;
    logic        w_resp;
    logic        w_mis;

    assign w_any    = m0_req | m1_req;
    assign w_start  = (r_state == S_IDLE) && w_any;
    assign w_access = (r_state == S_ACCESS);
    assign w_resp   = (r_state == S_RESP);

    // ls_op 10 and 11 are both byte accesses and can never be misaligned.
    assign w_mis = ((r_ls_op == 2'b00) && (r_addr[1:0] != 2'b00)) ||
                   ((r_ls_op == 2'b01) && r_addr[0]);

`ifdef DM_ARB_RR_EN
    // Last-winner pointer; reset to 1 so that m0 wins the first contest.
    logic r_last;

    always_comb begin
        if (m0_req && m1_req) w_win = ~r_last;
        else                  w_win = m1_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        r_last <= 1'b1;
        else if (w_start) r_last <= w_win;
    end
`else
    // Consecutive m0 grants taken while m1 was waiting. The extra headroom
    // keeps the width at least one bit for any MAX_BURST.
    localparam int CW = $clog2(MAX_BURST + 2);
    logic [CW-1:0] r_burst;

    assign w_win = m1_req && (!m0_req || (r_burst == CW'(MAX_BURST)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst <= '0;
        end else if (r_state == S_IDLE) begin
            if (!m1_req || (w_start && w_win)) r_burst <= '0;
            else if (w_start)                  r_burst <= r_burst + 1'b1;
        end
    end
`endif

    // NOTE: give every always_comb output a default before any branch so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_next = S_ACCESS;
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_win   <= 1'b0;
            r_we    <= 1'b0;
            r_ls_op <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_win   <= w_win;
                r_we    <= w_win ? m1_we    : m0_we;
                r_ls_op <= w_win ? m1_ls_op : m0_ls_op;
                r_addr  <= w_win ? m1_addr  : m0_addr;
                r_wdata <= w_win ? m1_wdata : m0_wdata;
            end
            // A misaligned access leaves the previous load data in place.
            if (w_access && !w_mis) r_rdata <= dm_rdata;
        end
    end

    // Outputs decode straight from the state register, so an async reset
    // removes dm_we and the pulses in the same cycle.
    assign dm_we    = w_access && r_we && !w_mis;
    assign dm_ls_op = w_access ? r_ls_op : 2'b00;
    assign dm_addr  = w_access ? r_addr  : 32'd0;
    assign dm_wdata = w_access ? r_wdata : 32'd0;

    assign m0_gnt  = w_access && !r_win;
    assign m1_gnt  = w_access &&  r_win;
    assign m0_done = w_resp   && !r_win;
    assign m1_done = w_resp   &&  r_win;
    assign m0_err  = w_resp   && !r_win && w_mis;
    assign m1_err  = w_resp   &&  r_win && w_mis;

    assign m_rdata = r_rdata;
    assign busy    = (r_state != S_IDLE);

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, maximum consecutive m0 grants while m1 waits (fixed-priority mode only).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports mN_req (N=0,1)  input  1  access request, held until mN_gnt.
REQ-005 SHALL have ports mN_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have ports mN_ls_op  input  2  width: 00 word, 01 half, 10 byte, 11 reserved (treated as byte).
REQ-007 SHALL have ports mN_addr  input  32  byte address.
REQ-008 SHALL have ports mN_wdata  input  32  store data, low-aligned.
REQ-009 SHALL have ports mN_gnt  output  1  one-cycle grant pulse.
REQ-010 SHALL have ports mN_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports mN_err  output  1  misalignment flag, valid with mN_done.
REQ-012 SHALL have port m_rdata  output  32  load data, valid with done.
REQ-013 SHALL have ports dm_we/dm_ls_op/dm_addr/dm_wdata  output  1/2/32/32  data-memory drive.
REQ-014 SHALL have port dm_rdata  input  32  combinational memory read data.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; ACCESS and RESP last exactly one cycle each.
REQ-017 In IDLE with any req high, SHALL select one winner, latch its we/ls_op/addr/wdata, record winner id, go to ACCESS; with no req, stay IDLE.
REQ-018 In ACCESS, SHALL drive dm_addr/dm_ls_op/dm_wdata from latched values, pulse winner's gnt, assert dm_we only if latched we=1 and aligned, capture dm_rdata into m_rdata at cycle end.
REQ-019 In RESP, SHALL pulse winner's done (and err if misaligned); m_rdata held until next capture.
REQ-020 Outside ACCESS, dm_we SHALL be 0 and dm_addr/dm_ls_op/dm_wdata SHALL be 0.
REQ-021 Misaligned = (word and addr[1:0]!=0) or (half and addr[0]!=0); misaligned access SHALL never assert dm_we and SHALL leave m_rdata unchanged; err=1 with done.
REQ-022 req inputs SHALL be ignored outside IDLE; requester drops req by the cycle its done is high; a still-high req in the IDLE after RESP is a new request.
REQ-023 Latency: request sampled at edge T -> gnt during T+1 -> done during T+2; throughput one access per 3 cycles.
REQ-024 gnt/done/err SHALL be one-hot across requesters and never asserted for the non-winner.

Reset
REQ-025 Reset SHALL immediately force IDLE, all outputs 0 (m_rdata=0, busy=0), latched request cleared, priority state to m0-first, burst counter 0.
REQ-026 Reset during ACCESS SHALL drop dm_we combinationally, abort the access and produce no done.

Configuration
REQ-027 Macro DM_ARB_RR_EN defined: round-robin; on simultaneous requests the requester not granted last wins; last-winner pointer updates on every grant.
REQ-028 DM_ARB_RR_EN undefined: m0 fixed priority; counter counts consecutive m0 grants while m1_req high; at MAX_BURST, next grant goes to m1; counter clears on m1 grant or m1_req low.
REQ-029 Single-requester behaviour SHALL be identical in both modes.

Verification
REQ-030 m0 store word addr 0x10 data 0xDEADBEEF -> m0_gnt at T+1 with dm_we=1, dm_addr=0x10; m0_done at T+2, err=0.
REQ-031 m1 load byte addr 0x13 after above -> dm_ls_op=10, m_rdata=0x000000DE with m1_done.
REQ-032 m0 store half addr 0x11 -> dm_we stays 0, m0_done=1 and m0_err=1, memory unchanged.
REQ-033 Both req held continuously, RR mode -> grants alternate m0,m1,m0,m1; fixed mode, MAX_BURST=4 -> m0 x4, m1 x1, repeat.
REQ-034 Reset asserted mid-ACCESS of a store -> dm_we=0 same cycle, no done, busy=0, next access wins m0-first.
